// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - default sizing constants and the DATA_W+1 -> DATA_W saturation helper
package bias_pkg;

  localparam int DEF_NUM_COLS = 4;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_BIAS_W   = 16;
  localparam int MAX_W        = 64;

  // Operates at the widest legal width so every lane instance can share it.
  function automatic logic signed [MAX_W-1:0] saturate(input logic signed [MAX_W:0] sum,
                                                       input int w);
    logic signed [MAX_W:0] lim;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    lim = 65'sd1 <<< (w - 1);
    hi  = lim - 65'sd1;
    lo  = -lim;
    if (sum > hi) begin
      return hi[MAX_W-1:0];
    end else if (sum < lo) begin
      return lo[MAX_W-1:0];
    end else begin
      return sum[MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bias_array_if.sv
// rtl/bias_array_if.sv - bias load/swap controls, systolic data in and biased results out
interface bias_array_if #(
  parameter int NUM_COLS = bias_pkg::DEF_NUM_COLS,
  parameter int DATA_W   = bias_pkg::DEF_DATA_W,
  parameter int BIAS_W   = bias_pkg::DEF_BIAS_W
);
  logic [NUM_COLS-1:0]        bias_load_en;
  logic [NUM_COLS*BIAS_W-1:0] bias_scalar_ub_in;
  logic                       bias_swap;
  logic                       relu_en;
  logic [NUM_COLS*DATA_W-1:0] bias_sys_data_in;
  logic [NUM_COLS-1:0]        bias_sys_valid_in;
  logic                       sat_clr;
  logic [NUM_COLS*DATA_W-1:0] bias_z_data_out;
  logic [NUM_COLS-1:0]        bias_Z_valid_out;
  logic                       bias_shadow_full;
  logic [NUM_COLS-1:0]        sat_flag;

  modport slave (
    input  bias_load_en, bias_scalar_ub_in, bias_swap, relu_en,
           bias_sys_data_in, bias_sys_valid_in, sat_clr,
    output bias_z_data_out, bias_Z_valid_out, bias_shadow_full, sat_flag
  );

  modport master (
    output bias_load_en, bias_scalar_ub_in, bias_swap, relu_en,
           bias_sys_data_in, bias_sys_valid_in, sat_clr,
    input  bias_z_data_out, bias_Z_valid_out, bias_shadow_full, sat_flag
  );
endinterface

// File: rtl/bias_lane.sv
// rtl/bias_lane.sv - one column: shadow/active bias, add stage, saturate+ReLU stage, sticky clip flag
module bias_lane
  import bias_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BIAS_W = DEF_BIAS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en_i,
  input  logic [BIAS_W-1:0] bias_i,
  input  logic              swap_i,
  input  logic              relu_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              sat_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              shadow_vld_o,
  output logic              sat_flag_o
);

  logic [BIAS_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic [DATA_W:0]   s1_sum_q, s1_sum_d;
  logic              s1_vld_q, s1_relu_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_vld_q;
  logic              sat_q, sat_d;
  logic signed [MAX_W:0] sum_ext;
  logic [DATA_W-1:0] sat_val;
  logic              clip;

  always_comb begin
    shadow_d     = load_en_i ? bias_i : shadow_q;
    shadow_vld_d = load_en_i | (shadow_vld_q & ~swap_i);
    // Swap reads the pre-load shadow, so a coincident load lands only in shadow.
    active_d     = (swap_i && shadow_vld_q) ? shadow_q : active_q;
    s1_sum_d     = {data_i[DATA_W-1], data_i}
                 + {{(DATA_W - BIAS_W + 1){active_q[BIAS_W-1]}}, active_q};
  end

  always_comb begin
    sum_ext = {{(MAX_W - DATA_W){s1_sum_q[DATA_W]}}, s1_sum_q};
    sat_val = DATA_W'(saturate(sum_ext, DATA_W));
    clip    = s1_sum_q[DATA_W] ^ s1_sum_q[DATA_W-1];
    out_d   = (s1_relu_q && sat_val[DATA_W-1]) ? '0 : sat_val;
    sat_d   = (s1_vld_q & clip) | (sat_q & ~sat_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      active_q     <= '0;
      s1_sum_q     <= '0;
      s1_vld_q     <= 1'b0;
      s1_relu_q    <= 1'b0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      active_q     <= active_d;
      s1_vld_q     <= valid_i;
      s1_relu_q    <= relu_en_i;
      out_vld_q    <= s1_vld_q;
      sat_q        <= sat_d;
      if (valid_i) begin
        s1_sum_q <= s1_sum_d;
      end
      if (s1_vld_q) begin
        out_q <= out_d;
      end
    end
  end

  assign data_o       = out_q;
  assign valid_o      = out_vld_q;
  assign shadow_vld_o = shadow_vld_q;
  assign sat_flag_o   = sat_q;

endmodule

// File: rtl/bias_array.sv
// rtl/bias_array.sv - NUM_COLS independent bias lanes with shared swap/relu/sat_clr controls
module bias_array
  import bias_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BIAS_W   = DEF_BIAS_W
) (
  input logic         clk,
  input logic         rst,
  bias_array_if.slave bus
);

  logic [NUM_COLS-1:0]        shadow_vld;
  logic [NUM_COLS-1:0]        valid_out;
  logic [NUM_COLS-1:0]        sat_out;
  logic [NUM_COLS*DATA_W-1:0] data_out;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
    bias_lane #(
      .DATA_W (DATA_W),
      .BIAS_W (BIAS_W)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .load_en_i    (bus.bias_load_en[i]),
      .bias_i       (bus.bias_scalar_ub_in[i*BIAS_W +: BIAS_W]),
      .swap_i       (bus.bias_swap),
      .relu_en_i    (bus.relu_en),
      .data_i       (bus.bias_sys_data_in[i*DATA_W +: DATA_W]),
      .valid_i      (bus.bias_sys_valid_in[i]),
      .sat_clr_i    (bus.sat_clr),
      .data_o       (data_out[i*DATA_W +: DATA_W]),
      .valid_o      (valid_out[i]),
      .shadow_vld_o (shadow_vld[i]),
      .sat_flag_o   (sat_out[i])
    );
  end

  assign bus.bias_z_data_out  = data_out;
  assign bus.bias_Z_valid_out = valid_out;
  assign bus.sat_flag         = sat_out;
  assign bus.bias_shadow_full = &shadow_vld;

endmodule

// File: tb/tb_bias_array.sv
// tb/tb_bias_array.sv - directed checks of bias_array with NUM_COLS=4, DATA_W=BIAS_W=16
module tb_bias_array;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bias_array_if #(.NUM_COLS(4), .DATA_W(16), .BIAS_W(16)) bus ();

  bias_array #(.NUM_COLS(4), .DATA_W(16), .BIAS_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bias(input int lane, input logic [15:0] v);
    bus.bias_scalar_ub_in[lane*16 +: 16] = v;
  endtask

  task automatic set_data(input int lane, input logic [15:0] v);
    bus.bias_sys_data_in[lane*16 +: 16] = v;
  endtask

  function automatic logic [15:0] out_lane(input int lane);
    return bus.bias_z_data_out[lane*16 +: 16];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.bias_load_en      = '0;
    bus.bias_scalar_ub_in = '0;
    bus.bias_swap         = 1'b0;
    bus.relu_en           = 1'b0;
    bus.bias_sys_data_in  = '0;
    bus.bias_sys_valid_in = '0;
    bus.sat_clr           = 1'b0;
    tick();
    chk("rst_valid", bus.bias_Z_valid_out, 4'h0);
    chk("rst_data", bus.bias_z_data_out, 64'h0);
    chk("rst_full", bus.bias_shadow_full, 1'b0);
    chk("rst_sat", bus.sat_flag, 4'h0);
    rst = 1'b0;
    tick();

    // load all lanes with 5, swap, data 100 -> 105
    bus.bias_load_en = 4'hF;
    for (int i = 0; i < 4; i++) set_bias(i, 16'd5);
    tick();
    bus.bias_load_en = 4'h0;
    chk("full_before_swap", bus.bias_shadow_full, 1'b1);
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_swap = 1'b0;
    chk("full_after_swap", bus.bias_shadow_full, 1'b0);
    set_data(0, 16'd100);
    bus.bias_sys_valid_in = 4'h1;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    chk("lat_not_1", bus.bias_Z_valid_out, 4'h0);
    tick();
    chk("basic_valid", bus.bias_Z_valid_out, 4'h1);
    chk("basic_data", out_lane(0), 16'd105);

    // active 10, shadow 20, swap with sample -> 11 then 21
    bus.bias_load_en = 4'h1;
    set_bias(0, 16'd10);
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_swap = 1'b0;
    bus.bias_load_en = 4'h1;
    set_bias(0, 16'd20);
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b1;
    set_data(0, 16'd1);
    bus.bias_sys_valid_in = 4'h1;
    tick();
    bus.bias_swap = 1'b0;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    chk("swap_cycle_old", out_lane(0), 16'd11);
    tick();
    chk("swap_next_new", out_lane(0), 16'd21);

    // saturation on lane 2, hold, clear, set-wins
    bus.bias_load_en = 4'h4;
    set_bias(2, 16'd100);
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_swap = 1'b0;
    set_data(2, 16'd32700);
    bus.bias_sys_valid_in = 4'h4;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("sat_data", out_lane(2), 16'h7FFF);
    chk("sat_valid", bus.bias_Z_valid_out, 4'h4);
    chk("sat_flag_set", bus.sat_flag, 4'h4);
    tick();
    chk("hold_valid", bus.bias_Z_valid_out, 4'h0);
    chk("hold_data2", out_lane(2), 16'h7FFF);
    chk("hold_data0", out_lane(0), 16'd21);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sat_clr", bus.sat_flag, 4'h0);
    bus.bias_sys_valid_in = 4'h4;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sat_set_wins", bus.sat_flag, 4'h4);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sat_clr2", bus.sat_flag, 4'h0);

    // ReLU per-sample on lane 3 with bias -50, data 20
    bus.bias_load_en = 4'h8;
    set_bias(3, 16'hFFCE);
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_swap = 1'b0;
    set_data(3, 16'd20);
    bus.bias_sys_valid_in = 4'h8;
    bus.relu_en = 1'b1;
    tick();
    bus.relu_en = 1'b0;
    tick();
    chk("relu_on", out_lane(3), 16'h0000);
    bus.relu_en = 1'b1;
    tick();
    chk("relu_off", out_lane(3), 16'hFFE2);
    bus.relu_en = 1'b0;
    tick();
    chk("relu_toggle_on", out_lane(3), 16'h0000);
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("relu_toggle_off", out_lane(3), 16'hFFE2);

    // partial swap: lane 1 unloaded keeps its bias
    bus.bias_load_en = 4'h1;
    set_bias(0, 16'd7);
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_swap = 1'b0;
    set_data(0, 16'd0);
    set_data(1, 16'd0);
    bus.bias_sys_valid_in = 4'h3;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("partial_l0", out_lane(0), 16'd7);
    chk("partial_l1", out_lane(1), 16'd5);

    // load+swap coincide on lane 1 with no pending shadow
    bus.bias_load_en = 4'h2;
    set_bias(1, 16'd30);
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b0;
    chk("coinc_full", bus.bias_shadow_full, 1'b0);
    bus.bias_sys_valid_in = 4'h2;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("coinc_l1_keep", out_lane(1), 16'd5);

    // load+swap coincide on lane 0 with pending shadow 40
    bus.bias_load_en = 4'h1;
    set_bias(0, 16'd40);
    tick();
    set_bias(0, 16'd50);
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_load_en = 4'h0;
    bus.bias_swap = 1'b0;
    bus.bias_sys_valid_in = 4'h3;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("coinc_l0_old", out_lane(0), 16'd40);
    chk("coinc_l1_prom", out_lane(1), 16'd30);
    bus.bias_swap = 1'b1;
    tick();
    bus.bias_swap = 1'b0;
    bus.bias_sys_valid_in = 4'h1;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("coinc_l0_new", out_lane(0), 16'd50);

    // reset with samples in flight
    bus.bias_load_en = 4'hF;
    tick();
    bus.bias_load_en = 4'h0;
    chk("pre_rst_full", bus.bias_shadow_full, 1'b1);
    for (int i = 0; i < 4; i++) set_data(i, 16'd1);
    bus.bias_sys_valid_in = 4'hF;
    tick();
    #2;
    rst = 1'b1;
    #1;
    bus.bias_sys_valid_in = 4'h0;
    chk("async_rst_valid", bus.bias_Z_valid_out, 4'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_valid", bus.bias_Z_valid_out, 4'h0);
    end
    chk("post_rst_data", bus.bias_z_data_out, 64'h0);
    chk("post_rst_full", bus.bias_shadow_full, 1'b0);
    chk("post_rst_sat", bus.sat_flag, 4'h0);
    set_data(0, 16'd3);
    bus.bias_sys_valid_in = 4'h1;
    tick();
    bus.bias_sys_valid_in = 4'h0;
    tick();
    chk("post_rst_bias0", out_lane(0), 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
